// File: rtl/pwm_simple_core.sv
// pwm_simple_core: fixed-duty, phase-correct (centre-aligned) PWM generator.
// An up/down counter sweeps 0..MAX..0. A registered compare against the
// static duty threshold drives the output pin, so the period is 2*MAX clocks
// and the high time is 2*PWM_DUTY_CYCLE clocks.
module pwm_simple_core #(
  parameter int unsigned PWM_RES        = 8,
  parameter int unsigned PWM_DUTY_CYCLE = 127
) (
  input  logic clock,
  input  logic reset_n,
  output logic pwm_output
);

  localparam int unsigned MAX_I = (1 << PWM_RES) - 1;
  localparam int unsigned CMP_W = PWM_RES + 1;

  localparam logic [PWM_RES-1:0] CNT_MAX    = PWM_RES'(MAX_I);
  localparam logic [PWM_RES-1:0] CNT_MAX_M1 = PWM_RES'(MAX_I - 1);
  localparam logic [PWM_RES-1:0] CNT_ONE    = PWM_RES'(1);
  localparam logic [PWM_RES-1:0] CNT_ZERO   = '0;

  // The threshold is compared one bit wider than the counter, so that a duty
  // of MAX still compares correctly against count == MAX.
  localparam logic [CMP_W-1:0] DUTY = CMP_W'(PWM_DUTY_CYCLE);

  // Reject illegal configurations when the design is elaborated.
  generate
    if (PWM_RES < 2 || PWM_RES > 16) begin : g_bad_res
      $error("pwm_simple_core: PWM_RES=%0d outside legal range 2..16", PWM_RES);
    end
    if (PWM_DUTY_CYCLE > MAX_I) begin : g_bad_duty
      $error("pwm_simple_core: PWM_DUTY_CYCLE=%0d exceeds 2^PWM_RES-1=%0d",
             PWM_DUTY_CYCLE, MAX_I);
    end
  endgenerate

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PWM_RES-1:0] count_q, count_d;
  dir_e               dir_q, dir_d;
  logic               pwm_q, pwm_d;
  logic [CMP_W-1:0]   count_ext;

  assign count_ext = {1'b0, count_q};

  // Next counter/direction state, plus the compare against the current state.
  // Each endpoint (MAX and 0) is visited for exactly one clock.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    pwm_d   = 1'b0;
    if (dir_q == DIR_UP) begin
      pwm_d = (count_ext < DUTY);
      if (count_q == CNT_MAX_M1) begin
        count_d = CNT_MAX;
        dir_d   = DIR_DOWN;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      // count >= 1 throughout the down phase, so no explicit != 0 term.
      pwm_d = (count_ext <= DUTY);
      if (count_q == CNT_ONE) begin
        count_d = CNT_ZERO;
        dir_d   = DIR_UP;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // State and registered output; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= CNT_ZERO;
      dir_q   <= DIR_UP;
      pwm_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_output = pwm_q;

endmodule

// File: tb/tb_pwm_simple_core.sv
// Scoreboard bench for pwm_simple_core. Six instances run from a shared clock
// and reset: PWM_RES=8 with D=63/127/191/255/0, and PWM_RES=4 with D=5. The
// stimulus process pushes the expected waveform for every edge into a queue.
// A monitor pops and compares at each falling edge, or on request right after
// an asynchronous reset.
module tb_pwm_simple_core;

  logic clock;
  logic reset_n;
  logic pwm63, pwm127, pwm191, pwm255, pwm0, pwm_r4;

  pwm_simple_core #(.PWM_RES(8), .PWM_DUTY_CYCLE(63))  u_d63  (.clock(clock), .reset_n(reset_n), .pwm_output(pwm63));
  pwm_simple_core #(.PWM_RES(8), .PWM_DUTY_CYCLE(127)) u_d127 (.clock(clock), .reset_n(reset_n), .pwm_output(pwm127));
  pwm_simple_core #(.PWM_RES(8), .PWM_DUTY_CYCLE(191)) u_d191 (.clock(clock), .reset_n(reset_n), .pwm_output(pwm191));
  pwm_simple_core #(.PWM_RES(8), .PWM_DUTY_CYCLE(255)) u_d255 (.clock(clock), .reset_n(reset_n), .pwm_output(pwm255));
  pwm_simple_core #(.PWM_RES(8), .PWM_DUTY_CYCLE(0))   u_d0   (.clock(clock), .reset_n(reset_n), .pwm_output(pwm0));
  pwm_simple_core #(.PWM_RES(4), .PWM_DUTY_CYCLE(5))   u_r4   (.clock(clock), .reset_n(reset_n), .pwm_output(pwm_r4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         k;      // edges since reset release (0 = in reset)
    string      tag;
    logic [5:0] pwm;    // {r4, d0, d255, d191, d127, d63}
    logic [3:0] cnt;    // PWM_RES=4 counter after this edge
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Hand-derived waveform: high for edges 1..D and for 2*MAX-D+1..2*MAX.
  function automatic logic pwm_model(int k, int maxv, int d);
    int p;
    int r;
    if (k == 0) return 1'b0;
    p = 2 * maxv;
    r = k % p;
    if (r == 0) r = p;
    return (r <= d) || (r > p - d);
  endfunction

  // Counter after edge k: rises 0..MAX, then falls back to 0.
  function automatic logic [3:0] cnt_model(int k, int maxv);
    int i;
    if (k == 0) return 4'd0;
    i = k % (2 * maxv);
    return (i <= maxv) ? 4'(i) : 4'(2 * maxv - i);
  endfunction

  function automatic exp_t make_exp(int k, string tag);
    exp_t e;
    e.k   = k;
    e.tag = tag;
    e.pwm = {pwm_model(k, 15, 5), pwm_model(k, 255, 0), pwm_model(k, 255, 255),
             pwm_model(k, 255, 191), pwm_model(k, 255, 127), pwm_model(k, 255, 63)};
    e.cnt = cnt_model(k, 15);
    return e;
  endfunction

  task automatic hold_reset(int cycles, string tag);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      exp_q.push_back(make_exp(0, tag));
    end
  endtask

  task automatic run_edges(int n, string tag);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      exp_q.push_back(make_exp(k, tag));
    end
  endtask

  // Monitor: compare the oldest expectation against the DUT outputs.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clock or chk_ev);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {pwm_r4, pwm0, pwm255, pwm191, pwm127, pwm63};
        checks++;
        if (act !== e.pwm) begin
          errors++;
          if (errors < 40)
            $display("FAIL pwm_%s k=%0d actual=%b required=%b", e.tag, e.k, act, e.pwm);
        end
        checks++;
        if (u_r4.count_q !== e.cnt) begin
          errors++;
          if (errors < 40)
            $display("FAIL count_r4_%s k=%0d actual=%0d required=%0d", e.tag, e.k, u_r4.count_q, e.cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin
    exp_t e;
    reset_n = 1'b0;
    hold_reset(3, "reset");
    $display("phase reset: 3 edges held in reset, all outputs expected low");

    @(negedge clock);
    #1 reset_n = 1'b1;
    run_edges(2000, "run1");
    $display("phase run1: 2000 edges free-running from reset release");

    // Run into the D=127 high pulse, then reset between edges.
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    run_edges(50, "pre_async");
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    e = make_exp(0, "async_drop");
    exp_q.push_back(e);
    -> chk_ev;
    $display("phase async: reset asserted mid-pulse at edge 50, immediate drop expected");
    hold_reset(2, "async_hold");

    @(negedge clock);
    #1 reset_n = 1'b1;
    run_edges(1100, "run2");
    $display("phase run2: 1100 edges after mid-period reset, fresh waveform expected");

    // Give the monitor a bounded window to drain the queue.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    stim_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
